// File: rtl/dragonfang_pkg.sv
// Shared core definitions: vector length, element-width modes and reduction opcodes.
// elem_count() maps an element-width mode to its element count (0 for unsupported modes).
package dragonfang_pkg;

  localparam int VLEN      = 64;
  localparam int MAX_ELEMS = VLEN / 8;

  typedef enum logic [2:0] {
    BM_8BIT  = 3'd0,
    BM_16BIT = 3'd1,
    BM_32BIT = 3'd2,
    BM_64BIT = 3'd3
  } bit_mode_t;

  typedef struct packed {
    bit_mode_t bit_mode;
  } execution_vector_t;

  typedef enum logic [2:0] {
    RED_SUM  = 3'd0,
    RED_AND  = 3'd1,
    RED_OR   = 3'd2,
    RED_XOR  = 3'd3,
    RED_MAX  = 3'd4,
    RED_MIN  = 3'd5,
    RED_MAXU = 3'd6,
    RED_MINU = 3'd7
  } reduction_op_t;

  function automatic logic [3:0] elem_count(bit_mode_t mode);
    case (mode)
      BM_8BIT:  return 4'd8;
      BM_16BIT: return 4'd4;
      BM_32BIT: return 4'd2;
      BM_64BIT: return 4'd1;
      default:  return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/vector_reduction_unit_pkg.sv
// Local types and element-width helpers for the vector reduction unit.
package vector_reduction_unit_pkg;
  import dragonfang_pkg::*;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic [VLEN-1:0] sew_mask(bit_mode_t mode);
    case (mode)
      BM_8BIT:  return {{(VLEN-8){1'b0}}, 8'hFF};
      BM_16BIT: return {{(VLEN-16){1'b0}}, 16'hFFFF};
      BM_32BIT: return {{(VLEN-32){1'b0}}, 32'hFFFF_FFFF};
      BM_64BIT: return '1;
      default:  return '0;
    endcase
  endfunction

  function automatic logic [VLEN-1:0] sign_extend(logic [VLEN-1:0] value, bit_mode_t mode);
    case (mode)
      BM_8BIT:  return {{(VLEN-8){value[7]}}, value[7:0]};
      BM_16BIT: return {{(VLEN-16){value[15]}}, value[15:0]};
      BM_32BIT: return {{(VLEN-32){value[31]}}, value[31:0]};
      BM_64BIT: return value;
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/vector_reduction_unit_if.sv
// Request/response bundle between the issue stage (master) and the reduction unit (slave).
interface vector_reduction_unit_if;
  import dragonfang_pkg::*;

  logic              in_valid;
  logic              in_ready;
  execution_vector_t execution_vector;
  reduction_op_t     reduction_op;
  logic [VLEN-1:0]   vector_input;
  logic [MAX_ELEMS-1:0] element_mask;
  logic [VLEN-1:0]   scalar_seed;
  logic              result_valid;
  logic              result_ready;
  logic [VLEN-1:0]   scalar_result;

  modport master (
    output in_valid, execution_vector, reduction_op, vector_input, element_mask,
           scalar_seed, result_ready,
    input  in_ready, result_valid, scalar_result
  );

  modport slave (
    input  in_valid, execution_vector, reduction_op, vector_input, element_mask,
           scalar_seed, result_ready,
    output in_ready, result_valid, scalar_result
  );

endinterface

// File: rtl/vector_reduction_unit_alu.sv
// Combines the accumulator with one element at the current element width.
// Both operands arrive zero-padded; the result is truncated back to SEW bits.
module reduction_element_alu
  import dragonfang_pkg::*;
  import vector_reduction_unit_pkg::*;
(
  input  reduction_op_t   op,
  input  bit_mode_t       sew,
  input  logic [VLEN-1:0] acc,
  input  logic [VLEN-1:0] elem,
  output logic [VLEN-1:0] result
);

  logic signed [VLEN-1:0] acc_s;
  logic signed [VLEN-1:0] elem_s;
  logic        [VLEN-1:0] raw;

  always_comb begin
    acc_s  = sign_extend(acc, sew);
    elem_s = sign_extend(elem, sew);
    raw    = acc;
    case (op)
      RED_SUM:  raw = acc + elem;
      RED_AND:  raw = acc & elem;
      RED_OR:   raw = acc | elem;
      RED_XOR:  raw = acc ^ elem;
      RED_MAX:  raw = (elem_s > acc_s) ? elem : acc;
      RED_MIN:  raw = (elem_s < acc_s) ? elem : acc;
      RED_MAXU: raw = (elem > acc) ? elem : acc;
      RED_MINU: raw = (elem < acc) ? elem : acc;
      default:  raw = acc;
    endcase
    result = raw & sew_mask(sew);
  end

endmodule

// File: rtl/vector_reduction_unit.sv
// Folds the active elements of one vector operand into a seed scalar, one element per cycle,
// and returns the sign-extended result over a valid/ready handshake.
module vector_reduction_unit
  import dragonfang_pkg::*;
  import vector_reduction_unit_pkg::*;
(
  input logic clock,
  input logic reset,
  vector_reduction_unit_if.slave bus
);

  state_t               state_q, state_d;
  logic [2:0]           index_q, index_d;
  logic [VLEN-1:0]      acc_q, acc_d;
  logic [VLEN-1:0]      result_q, result_d;
  logic [VLEN-1:0]      operand_q, operand_d;
  logic [MAX_ELEMS-1:0] mask_q, mask_d;
  reduction_op_t        op_q, op_d;
  bit_mode_t            mode_q, mode_d;

  logic [5:0]      shift_amt;
  logic [VLEN-1:0] elem;
  logic [VLEN-1:0] alu_result;
  logic [VLEN-1:0] acc_next;
  logic [3:0]      n_elems;
  logic [2:0]      last_index;

  always_comb begin
    shift_amt = 6'd0;
    case (mode_q)
      BM_8BIT:  shift_amt = {index_q, 3'b000};
      BM_16BIT: shift_amt = {index_q[1:0], 4'b0000};
      BM_32BIT: shift_amt = {index_q[0], 5'b00000};
      default:  shift_amt = 6'd0;
    endcase
    elem = (operand_q >> shift_amt) & sew_mask(mode_q);
  end

  reduction_element_alu u_alu (
    .op     (op_q),
    .sew    (mode_q),
    .acc    (acc_q),
    .elem   (elem),
    .result (alu_result)
  );

  // Eight elements wrap the 3-bit count to 0, so 0 - 1 still lands on index 7.
  assign n_elems    = elem_count(mode_q);
  assign last_index = n_elems[2:0] - 3'd1;
  assign acc_next   = mask_q[index_q] ? alu_result : acc_q;

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    acc_d     = acc_q;
    result_d  = result_q;
    operand_d = operand_q;
    mask_d    = mask_q;
    op_d      = op_q;
    mode_d    = mode_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          operand_d = bus.vector_input;
          mask_d    = bus.element_mask;
          op_d      = bus.reduction_op;
          mode_d    = bus.execution_vector.bit_mode;
          index_d   = 3'd0;
          acc_d     = bus.scalar_seed & sew_mask(bus.execution_vector.bit_mode);
          if (elem_count(bus.execution_vector.bit_mode) == 4'd0) begin
            acc_d    = '0;
            result_d = '0;
            state_d  = DONE;
          end else begin
            state_d = REDUCE;
          end
        end
      end
      REDUCE: begin
        acc_d   = acc_next;
        index_d = index_q + 3'd1;
        if (index_q == last_index) begin
          result_d = sign_extend(acc_next, mode_q);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      index_q   <= 3'd0;
      acc_q     <= '0;
      result_q  <= '0;
      operand_q <= '0;
      mask_q    <= '0;
      op_q      <= RED_SUM;
      mode_q    <= BM_8BIT;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      operand_q <= operand_d;
      mask_q    <= mask_d;
      op_q      <= op_d;
      mode_q    <= mode_d;
    end
  end

  assign bus.in_ready      = (state_q == IDLE);
  assign bus.result_valid  = (state_q == DONE);
  assign bus.scalar_result = result_q;

endmodule
